// File: rtl/cic_array_sched.sv
// Configuration sequencer and round-robin output serialiser for an array of CIC decimators.
// Define CIC_SCHED_TSTAMP_EN to add the m_tstamp output, which carries the capture cycle of each sample.
module cic_array_sched #(
    parameter int         NUM_CH     = 4,
    parameter int         CH_W       = 2,
    parameter int         DATA_W     = 32,
    parameter int         RST_CYCLES = 4,
    parameter logic [2:0] DEF_COMB   = 3'd1,
    parameter logic [7:0] DEF_DEC    = 8'd63
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 cfg_comb_num,
    input  logic [7:0]                 cfg_dec_num,
    input  logic                       cfg_load,
    output logic                       cic_rst,
    output logic [2:0]                 cic_comb_num,
    output logic [7:0]                 cic_dec_num,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    input  logic [NUM_CH-1:0]          ch_valid,
    output logic [DATA_W-1:0]          m_data,
    output logic [CH_W-1:0]            m_chan,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [NUM_CH-1:0]          overrun,
    input  logic                       overrun_clr,
    output logic                       busy
`ifdef CIC_SCHED_TSTAMP_EN
   ,output logic [31:0]                m_tstamp
`endif
);

    localparam int CNT_W = $clog2(RST_CYCLES + 1);

    // state | meaning
    // HOLD  | CIC array held in reset for RST_CYCLES cycles
    // RUN   | capturing channel pulses and serialising them
    // DRAIN | flushing pending samples before a config change
    typedef enum logic [1:0] {HOLD, RUN, DRAIN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_sh_comb;
    logic [7:0]          r_sh_dec;
    logic [DATA_W-1:0]   r_hold [NUM_CH];
    logic [NUM_CH-1:0]   r_pend;
    logic [CH_W-1:0]     r_ptr;

    logic                w_free;
    logic                w_any;
    logic [CH_W:0]       w_idx;
    logic [CH_W-1:0]     w_gidx;
    logic [CH_W-1:0]     w_ptr_nxt;
    logic [NUM_CH-1:0]   w_gnt;
    logic [NUM_CH-1:0]   w_cap;
    logic [NUM_CH-1:0]   w_ovset;

    always_ff @(posedge clk) begin
        if (rst) r_state <= HOLD;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HOLD:    if (r_cnt == '0) w_state_nxt = RUN;
            RUN:     if (cfg_load) w_state_nxt = DRAIN;
            DRAIN:   if (r_pend == '0 && !m_valid) w_state_nxt = HOLD;
            default: w_state_nxt = HOLD;
        endcase
    end

    assign busy  = (r_state != RUN);
    assign w_cap = (r_state == RUN) ? ch_valid : '0;

    // Round-robin search starting at the pointer, wrapping at NUM_CH.
    always_comb begin
        w_free = !m_valid || m_ready;
        w_any  = 1'b0;
        w_gidx = '0;
        w_idx  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = {1'b0, r_ptr} + (CH_W+1)'(i);
            if (w_idx >= (CH_W+1)'(NUM_CH)) w_idx = w_idx - (CH_W+1)'(NUM_CH);
            if (!w_any && r_pend[w_idx[CH_W-1:0]]) begin
                w_any  = 1'b1;
                w_gidx = w_idx[CH_W-1:0];
            end
        end
        w_gnt = '0;
        if (w_free && w_any) w_gnt[w_gidx] = 1'b1;
        w_ptr_nxt = (w_gidx == CH_W'(NUM_CH-1)) ? '0 : w_gidx + CH_W'(1);
        w_ovset   = w_cap & r_pend & ~w_gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend  <= '0;
            r_ptr   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_chan  <= '0;
            overrun <= '0;
            for (int k = 0; k < NUM_CH; k++) r_hold[k] <= '0;
        end else begin
            if (w_free) begin
                if (w_any) begin
                    m_valid <= 1'b1;
                    m_data  <= r_hold[w_gidx];
                    m_chan  <= w_gidx;
                    r_ptr   <= w_ptr_nxt;
                end else begin
                    m_valid <= 1'b0;
                end
            end
            // A grant reads the old held value even if the same channel captures this cycle.
            for (int k = 0; k < NUM_CH; k++)
                if (w_cap[k]) r_hold[k] <= ch_data[k*DATA_W +: DATA_W];
            r_pend  <= (r_pend & ~w_gnt) | w_cap;
            overrun <= (overrun & ~{NUM_CH{overrun_clr}}) | w_ovset;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= CNT_W'(RST_CYCLES - 1);
            cic_rst      <= 1'b1;
            cic_comb_num <= DEF_COMB;
            cic_dec_num  <= DEF_DEC;
            r_sh_comb    <= DEF_COMB;
            r_sh_dec     <= DEF_DEC;
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_cnt == '0) cic_rst <= 1'b0;
                    else             r_cnt   <= r_cnt - CNT_W'(1);
                end
                RUN: begin
                    if (cfg_load) begin
                        r_sh_comb <= cfg_comb_num;
                        r_sh_dec  <= cfg_dec_num;
                    end
                end
                DRAIN: begin
                    if (w_state_nxt == HOLD) begin
                        cic_comb_num <= r_sh_comb;
                        cic_dec_num  <= r_sh_dec;
                        cic_rst      <= 1'b1;
                        r_cnt        <= CNT_W'(RST_CYCLES - 1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CIC_SCHED_TSTAMP_EN
    logic [31:0] r_tcnt;
    logic [31:0] r_hold_ts [NUM_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt   <= '0;
            m_tstamp <= '0;
            for (int k = 0; k < NUM_CH; k++) r_hold_ts[k] <= '0;
        end else begin
            r_tcnt <= r_tcnt + 32'd1;
            if (w_free && w_any) m_tstamp <= r_hold_ts[w_gidx];
            for (int k = 0; k < NUM_CH; k++)
                if (w_cap[k]) r_hold_ts[k] <= r_tcnt;
        end
    end
`endif

endmodule

// File: tb/tb_cic_array_sched.sv
// Self-checking bench for cic_array_sched: spec-level cycle model plus directed scenarios.
module tb_cic_array_sched;
    localparam int NUM_CH     = 4;
    localparam int CH_W       = 2;
    localparam int DATA_W     = 32;
    localparam int RST_CYCLES = 4;
    localparam int PH_HOLD = 0, PH_RUN = 1, PH_DRAIN = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [2:0]               cfg_comb_num = '0;
    logic [7:0]               cfg_dec_num = '0;
    logic                     cfg_load = 1'b0;
    logic                     cic_rst;
    logic [2:0]               cic_comb_num;
    logic [7:0]               cic_dec_num;
    logic [NUM_CH*DATA_W-1:0] ch_data = '0;
    logic [NUM_CH-1:0]        ch_valid = '0;
    logic [DATA_W-1:0]        m_data;
    logic [CH_W-1:0]          m_chan;
    logic                     m_valid;
    logic                     m_ready = 1'b0;
    logic [NUM_CH-1:0]        overrun;
    logic                     overrun_clr = 1'b0;
    logic                     busy;

    cic_array_sched #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .RST_CYCLES(RST_CYCLES),
        .DEF_COMB(3'd1), .DEF_DEC(8'd63)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_comb_num(cfg_comb_num), .cfg_dec_num(cfg_dec_num), .cfg_load(cfg_load),
        .cic_rst(cic_rst), .cic_comb_num(cic_comb_num), .cic_dec_num(cic_dec_num),
        .ch_data(ch_data), .ch_valid(ch_valid),
        .m_data(m_data), .m_chan(m_chan), .m_valid(m_valid), .m_ready(m_ready),
        .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy)
    );

    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: stepped once per rising edge from the sampled inputs.
    bit                md_ok = 1'b0;
    int                md_phase, md_hcyc, md_ptr, md_mchan, md_g, md_kk, cyc;
    bit                md_rst, md_mv, md_free, md_old_mv, md_old_any;
    int                md_comb, md_dec, md_shc, md_shd;
    logic [DATA_W-1:0] md_mdata;
    logic [DATA_W-1:0] md_hold [NUM_CH];
    bit                md_pend [NUM_CH];
    bit [NUM_CH-1:0]   md_ov, md_cap;
    int                xq_chan[$];
    logic [DATA_W-1:0] xq_data[$];
    int                xq_cyc[$];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            md_ok = 1'b1; md_phase = PH_HOLD; md_hcyc = 0; md_rst = 1'b1;
            md_comb = 1; md_dec = 63; md_shc = 1; md_shd = 63;
            md_mv = 1'b0; md_mdata = '0; md_mchan = 0; md_ov = '0; md_ptr = 0;
            for (int k = 0; k < NUM_CH; k++) begin md_pend[k] = 1'b0; md_hold[k] = '0; end
        end else begin
            md_old_mv  = md_mv;
            md_old_any = 1'b0;
            for (int k = 0; k < NUM_CH; k++) if (md_pend[k]) md_old_any = 1'b1;
            md_free = !md_mv || m_ready;
            if (md_mv && m_ready) begin
                xq_chan.push_back(md_mchan); xq_data.push_back(md_mdata); xq_cyc.push_back(cyc);
            end
            md_g = -1;
            if (md_free)
                for (int j = 0; j < NUM_CH; j++) begin
                    md_kk = (md_ptr + j) % NUM_CH;
                    if (md_g < 0 && md_pend[md_kk]) md_g = md_kk;
                end
            if (overrun_clr) md_ov = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                md_cap[k] = (md_phase == PH_RUN) && ch_valid[k];
                if (md_cap[k] && md_pend[k] && md_g != k) md_ov[k] = 1'b1;
            end
            if (md_free) begin
                if (md_g >= 0) begin
                    md_mdata = md_hold[md_g]; md_mchan = md_g; md_mv = 1'b1;
                    md_pend[md_g] = 1'b0; md_ptr = (md_g + 1) % NUM_CH;
                end else begin
                    md_mv = 1'b0;
                end
            end
            for (int k = 0; k < NUM_CH; k++)
                if (md_cap[k]) begin md_hold[k] = ch_data[k*DATA_W +: DATA_W]; md_pend[k] = 1'b1; end
            case (md_phase)
                PH_HOLD: begin
                    md_hcyc++;
                    if (md_hcyc == RST_CYCLES) begin md_phase = PH_RUN; md_rst = 1'b0; end
                end
                PH_RUN: if (cfg_load) begin md_shc = cfg_comb_num; md_shd = cfg_dec_num; md_phase = PH_DRAIN; end
                default: if (!md_old_any && !md_old_mv) begin
                    md_comb = md_shc; md_dec = md_shd; md_rst = 1'b1; md_hcyc = 0; md_phase = PH_HOLD;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (md_ok) begin
            chk("m_valid", m_valid, md_mv);
            if (md_mv) begin
                chk("m_data", m_data, md_mdata);
                chk("m_chan", m_chan, md_mchan);
            end
            chk("overrun", overrun, md_ov);
            chk("cic_rst", cic_rst, md_rst);
            chk("cic_comb_num", cic_comb_num, md_comb);
            chk("cic_dec_num", cic_dec_num, md_dec);
            chk("busy", busy, md_phase != PH_RUN);
        end
    end

    int xbase = 0;
    int cnt;

    task automatic tick(); @(negedge clk); endtask
    task automatic set_ch(input int k, input logic [DATA_W-1:0] d); ch_data[k*DATA_W +: DATA_W] = d; endtask
    task automatic pulse(input logic [NUM_CH-1:0] m); ch_valid = m; tick(); ch_valid = '0; endtask
    task automatic mark(); xbase = xq_chan.size(); endtask
    task automatic wait_xfers(input int n, input string name);
        for (int i = 0; i < 40 && xq_chan.size() < xbase + n; i++) tick();
        chk(name, xq_chan.size() - xbase, n);
    endtask
    task automatic chk_x(input int i, input int ch, input logic [DATA_W-1:0] d);
        if (xq_chan.size() > xbase + i) begin
            chk("xfer_chan", xq_chan[xbase+i], ch);
            chk("xfer_data", xq_data[xbase+i], d);
        end else begin
            chk("xfer_missing", xq_chan.size() - xbase, i + 1);
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_cic_rst", cic_rst, 1); chk("rst_busy", busy, 1);
        chk("rst_comb", cic_comb_num, 1); chk("rst_dec", cic_dec_num, 63);
        chk("rst_m_valid", m_valid, 0); chk("rst_m_data", m_data, 0);
        chk("rst_m_chan", m_chan, 0); chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && cic_rst; i++) begin cnt++; tick(); end
        chk("release_len", cnt, 4);
        chk("release_busy", busy, 0);

        // all four channels at once
        m_ready = 1'b1; mark();
        for (int k = 0; k < NUM_CH; k++) set_ch(k, 32'hA0 + k);
        pulse(4'b1111);
        wait_xfers(4, "burst_count");
        for (int i = 0; i < 4; i++) chk_x(i, i, 32'hA0 + i);
        if (xq_cyc.size() >= xbase + 4)
            chk("burst_b2b", xq_cyc[xbase+3] - xq_cyc[xbase], 3);
        chk("burst_overrun", overrun, 0);

        // pointer sits at 0 after ch3 grant
        mark(); set_ch(0, 32'hB0); set_ch(3, 32'hB3);
        pulse(4'b1001);
        wait_xfers(2, "fair_count");
        chk_x(0, 0, 32'hB0); chk_x(1, 3, 32'hB3);

        // pointer at 2 after ch1 grant: ch3 must win over ch0
        mark(); set_ch(1, 32'hC1);
        pulse(4'b0010);
        wait_xfers(1, "ptr_first");
        set_ch(0, 32'hC0); set_ch(3, 32'hC3);
        pulse(4'b1001);
        wait_xfers(3, "ptr_count");
        chk_x(0, 1, 32'hC1); chk_x(1, 3, 32'hC3); chk_x(2, 0, 32'hC0);

        // overrun under backpressure
        m_ready = 1'b0; mark();
        set_ch(1, 32'h55); pulse(4'b0010); tick();
        set_ch(2, 32'h11); pulse(4'b0100); tick();
        set_ch(2, 32'h22); pulse(4'b0100);
        repeat (15) tick();
        chk("ovr_flag", overrun, 4'b0100);
        chk("ovr_hold_valid", m_valid, 1); chk("ovr_hold_chan", m_chan, 1); chk("ovr_hold_data", m_data, 32'h55);
        m_ready = 1'b1;
        wait_xfers(2, "ovr_count");
        chk_x(0, 1, 32'h55); chk_x(1, 2, 32'h22);
        chk("ovr_sticky", overrun, 4'b0100);
        overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
        chk("ovr_cleared", overrun, 0);

        // clear and fresh overrun in the same cycle: the set wins
        m_ready = 1'b0; mark();
        set_ch(0, 32'h1); pulse(4'b0001); tick();
        set_ch(3, 32'h2); pulse(4'b1000); tick();
        set_ch(3, 32'h3); pulse(4'b1000); tick();
        chk("ovr3_set", overrun, 4'b1000);
        set_ch(1, 32'h4); pulse(4'b0010); tick();
        set_ch(1, 32'h5); overrun_clr = 1'b1; pulse(4'b0010); overrun_clr = 1'b0;
        chk("ovr_clr_race", overrun, 4'b0010);
        m_ready = 1'b1;
        wait_xfers(3, "race_count");
        chk_x(0, 0, 32'h1); chk_x(1, 1, 32'h5); chk_x(2, 3, 32'h3);
        overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;

        // reconfiguration with two samples pending
        mark();
        set_ch(0, 32'hD0); set_ch(1, 32'hD1); set_ch(2, 32'hD2);
        cfg_comb_num = 3'd5; cfg_dec_num = 8'd99; cfg_load = 1'b1;
        ch_valid = 4'b0011; tick();
        cfg_load = 1'b0; ch_valid = 4'b0100; tick(); ch_valid = '0;
        chk("drain_busy", busy, 1);
        for (int i = 0; i < 20 && !cic_rst; i++) tick();
        ch_valid = 4'b1000; cnt = 0;
        for (int i = 0; i < 20 && cic_rst; i++) begin cnt++; tick(); ch_valid = '0; end
        chk("reconf_len", cnt, 4);
        chk("reconf_comb", cic_comb_num, 5); chk("reconf_dec", cic_dec_num, 99);
        repeat (5) tick();
        chk("reconf_count", xq_chan.size() - xbase, 2);
        chk_x(0, 0, 32'hD0); chk_x(1, 1, 32'hD1);

        // reset in the middle of a drain
        m_ready = 1'b0; mark();
        set_ch(0, 32'hE0); pulse(4'b0001); tick();
        cfg_comb_num = 3'd2; cfg_dec_num = 8'd10; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
        tick();
        chk("pre_rst_valid", m_valid, 1); chk("pre_rst_busy", busy, 1); chk("pre_rst_comb", cic_comb_num, 5);
        rst = 1'b1; tick();
        chk("mid_rst_valid", m_valid, 0); chk("mid_rst_busy", busy, 1); chk("mid_rst_cic_rst", cic_rst, 1);
        chk("mid_rst_comb", cic_comb_num, 1); chk("mid_rst_dec", cic_dec_num, 63);
        rst = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("post_rst_run", busy, 0);
        set_ch(0, 32'hF0); set_ch(3, 32'hF3);
        pulse(4'b1001);
        wait_xfers(2, "post_rst_count");
        chk_x(0, 0, 32'hF0); chk_x(1, 3, 32'hF3);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cic_array_sched.md
Name: cic_array_sched

Overview:
- Controller for an array of NUM_CH CIC decimator instances, one per PDM microphone.
- Broadcasts the comb/decimation configuration to the array.
- Applies configuration changes safely: drain, hold the CIC array in reset, release.
- Collects each instance's single-cycle output pulses and serialises them round-robin onto one valid/ready stream tagged with channel number, for the downstream correlation/bus logic.

Parameters:
- NUM_CH, 4, number of CIC channels (2..8)
- CH_W, 2, width of channel tag; must be ≥ clog2(NUM_CH)
- DATA_W, 32, CIC sample width
- RST_CYCLES, 4, cycles cic_rst is held after reset or reconfiguration (≥1)
- DEF_COMB, 3'd1, comb rate applied at reset
- DEF_DEC, 8'd63, decimation rate applied at reset

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- cfg_comb_num  in  3  requested comb rate
- cfg_dec_num  in  8  requested decimation rate
- cfg_load  in  1  one-cycle pulse; request to apply cfg_* values
- cic_rst  out  1  reset to all CIC instances
- cic_comb_num  out  3  comb rate to all CIC instances
- cic_dec_num  out  8  decimation rate to all CIC instances
- ch_data  in  NUM_CH*DATA_W  CIC outputs; channel k at bits [k*DATA_W +: DATA_W]
- ch_valid  in  NUM_CH  per-channel one-cycle valid pulses
- m_data  out  DATA_W  output sample
- m_chan  out  CH_W  channel tag of m_data
- m_valid  out  1  output valid
- m_ready  in  1  downstream accept
- overrun  out  NUM_CH  sticky per-channel overrun flags
- overrun_clr  in  1  one-cycle pulse; clears all overrun bits
- busy  out  1  high whenever state is not RUN

Behaviour:
- FSM states: HOLD, RUN, DRAIN.
- Reset: state HOLD; cic_rst=1; cic_comb_num=DEF_COMB; cic_dec_num=DEF_DEC; m_valid=0; m_data=0; m_chan=0; overrun=0; all pending=0; rr pointer=0; busy=1.
- HOLD:
  - cic_rst=1; counts RST_CYCLES cycles, then goes to RUN.
  - cic_rst is registered and deasserts on the same edge the state becomes RUN.
  - ch_valid is ignored.
- RUN:
  - Capture: ch_valid[k] loads holding reg k and sets pending[k].
  - If pending[k] is already set and is not granted that cycle: overrun[k] is set and the newer sample overwrites the held one.
- Grant:
  - Occurs when the output slot is free, i.e. !m_valid, or m_valid && m_ready.
  - Picks the first pending channel searching from the rr pointer upward, with wrap.
  - Loads m_data/m_chan, sets m_valid=1, clears that pending bit, sets pointer = granted+1 mod NUM_CH.
  - No pending channel in a free slot: m_valid goes to 0.
  - Output is registered: capture-to-m_valid latency is at least 2 cycles.
- Handshake:
  - While m_valid && !m_ready, m_data/m_chan/m_valid hold stable.
  - A transfer occurs on any edge with m_valid && m_ready.
  - Back-to-back grants, one per cycle, are supported.
- Simultaneous capture and grant on the same channel: the grant takes the old held value; the new value remains pending; no overrun.
- cfg_load: honoured only in RUN, ignored otherwise. Latches cfg_* into shadow registers and moves to DRAIN.
- DRAIN:
  - ch_valid is ignored.
  - Grants continue until no pending bits remain and m_valid=0.
  - Then loads cic_comb_num/cic_dec_num from the shadow registers and enters HOLD (RST_CYCLES reset pulse).
- overrun_clr clears all bits; a same-cycle overrun set wins for that channel.
- Reset mid-operation returns everything to reset values within one cycle; in-flight samples are discarded.

Optional Feature:
- CIC_SCHED_TSTAMP_EN defined:
  - Adds output m_tstamp [31:0] and a free-running 32-bit cycle counter (reset 0, wraps).
  - Each capture stores the counter value with the sample; m_tstamp travels with m_data under the same stability rules.
  - The counter runs in all states.
- Not defined: no port, no counter, no timestamp storage.

Test Plan:
- Reset release, NUM_CH=4 -> cic_rst=1 for 4 cycles after rst low, then 0; busy 1→0; cic_comb_num=1, cic_dec_num=63.
- ch_valid=4'b1111 in one cycle with data 0xA0..0xA3, m_ready=1 -> four consecutive transfers, m_chan 0,1,2,3, data matching; overrun=0.
- m_ready=0 for 20 cycles, ch_valid[2] pulsed twice (0x11, then 0x22) -> overrun[2]=1; on m_ready=1, channel 2 delivers 0x22; overrun_clr -> 0.
- Pointer fairness: after granting ch 3, pulse ch 0 and ch 3 together -> ch 0 granted before ch 3.
- cfg_load with comb=5, dec=99 while 2 samples pending, m_ready=1 -> both delivered, then cic_rst high for 4 cycles, outputs 5/99, ch_valid during DRAIN/HOLD dropped.
- rst asserted during DRAIN with m_valid=1 -> next cycle m_valid=0, state HOLD, config returns to DEF_COMB/DEF_DEC.
